valve_sequencer: RTL and testbench

VALVE_SEQUENCER -- requirements
Module: valve_sequencer

---
 rtl/valve_seq_pkg.sv | 35 +++
 rtl/instr_fifo.sv | 52 +++++
 rtl/valve_sequencer.sv | 135 +++++++++++++
 tb/tb_valve_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/valve_seq_pkg.sv
// rtl/valve_seq_pkg.sv - opcode, state and instruction-field definitions for the valve sequencer
package valve_seq_pkg;

  localparam int OPCODE_W  = 3;
  localparam int OPERAND_W = 10;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP       = 3'b000,
    OP_VALVE_ON  = 3'b001,
    OP_VALVE_OFF = 3'b010,
    OP_WAIT      = 3'b011,
    OP_SET_LO    = 3'b100,
    OP_SET_HI    = 3'b101,
    OP_CLEAR_ALL = 3'b110,
    OP_ILLEGAL   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [OPERAND_W-1:0]   operand;
  } instr_t;

  // Counter must hold the largest operand times the tick divider without wrapping.
  function automatic int wait_cnt_width(input int tick_div);
    return $clog2(((1 << OPERAND_W) - 1) * tick_div + 1);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous instruction FIFO with occupancy count and flush
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/valve_sequencer.sv
// rtl/valve_sequencer.sv - buffered instruction sequencer driving a bank of valve outputs
module valve_sequencer
  import valve_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_VALVES = 16,
  parameter int TICK_DIV   = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        instr_valid,
  input  logic [INSTR_W-1:0]          instruction,
  input  logic                        halt,
  output logic                        instr_ready,
  output logic [NUM_VALVES-1:0]       valves,
  output logic                        busy,
  output logic                        err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = wait_cnt_width(TICK_DIV);

  state_e                 state_q;
  state_e                 state_d;
  instr_t                 instr_q;
  logic [INSTR_W-1:0]     fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [NUM_VALVES-1:0]  valves_d;
  logic                   illegal;
  logic                   err_d;
  logic [3:0]             idx;
  logic                   idx_ok;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (instr_valid),
    .pop   (pop),
    .flush (halt),
    .wdata (instruction),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_ready = !fifo_full;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign idx         = instr_q.operand[3:0];
  assign idx_ok      = int'(idx) < NUM_VALVES;
  // Halt leaves the sticky error untouched, including a dropped concurrent push.
  assign err_d       = err | (!halt && ((instr_valid && fifo_full) || illegal));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
        ST_EXEC: begin
          if (instr_q.opcode == OP_WAIT && instr_q.operand != '0) state_d = ST_WAIT;
          else                                                     state_d = ST_IDLE;
        end
        ST_WAIT: if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    valves_d = valves;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    illegal  = 1'b0;
    if (halt) begin
      valves_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: pop = !fifo_empty;
        ST_EXEC: begin
          unique case (instr_q.opcode)
            OP_NOP: ;
            OP_VALVE_ON, OP_VALVE_OFF: begin
              if (!idx_ok) illegal = 1'b1;
              for (int i = 0; i < NUM_VALVES; i++)
                if (int'(idx) == i) valves_d[i] = (instr_q.opcode == OP_VALVE_ON);
            end
            OP_WAIT: cnt_d = CNT_W'(instr_q.operand) * CNT_W'(TICK_DIV);
            OP_SET_LO: begin
              for (int i = 0; i < 8; i++)
                if (i < NUM_VALVES) valves_d[i] = instr_q.operand[i];
            end
            OP_SET_HI: begin
              for (int i = 0; i < 8; i++)
                if (i + 8 < NUM_VALVES) valves_d[i+8] = instr_q.operand[i];
            end
            OP_CLEAR_ALL: valves_d = '0;
            default: illegal = 1'b1;
          endcase
        end
        ST_WAIT: cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valves  <= '0;
      err     <= 1'b0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      valves <= valves_d;
      err    <= err_d;
      cnt_q  <= cnt_d;
      if (pop) instr_q <= instr_t'(fifo_head);
    end
  end

endmodule

// File: tb/tb_valve_sequencer.sv
// tb/tb_valve_sequencer.sv - directed table-driven bench for valve_sequencer
module tb_valve_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [12:0] instruction;
  logic        halt;
  logic        instr_ready;
  logic [15:0] valves;
  logic        busy;
  logic        err;
  logic [3:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [12:0] instr;
    logic [15:0] exp_valves;
  } vec_t;

  vec_t        vecs [9];
  logic [12:0] burst [8];
  logic [15:0] burst_exp [8];
  logic [15:0] exp_prev;
  int          n;

  always #5 clk = ~clk;

  valve_sequencer #(
    .FIFO_DEPTH (8),
    .NUM_VALVES (16),
    .TICK_DIV   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .halt        (halt),
    .instr_ready (instr_ready),
    .valves      (valves),
    .busy        (busy),
    .err         (err),
    .fifo_count  (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [12:0] w);
    instr_valid = 1'b1;
    instruction = w;
    tick(1);
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{13'h0403, 16'h0008};
    vecs[1] = '{13'h040F, 16'h8008};
    vecs[2] = '{13'h10AA, 16'h80AA};
    vecs[3] = '{13'h1455, 16'h55AA};
    vecs[4] = '{13'h0801, 16'h55A8};
    vecs[5] = '{13'h0000, 16'h55A8};
    vecs[6] = '{13'h0C00, 16'h55A8};
    vecs[7] = '{13'h0432, 16'h55AC};
    vecs[8] = '{13'h1800, 16'h0000};

    burst[0] = 13'h1001; burst_exp[0] = 16'h0001;
    burst[1] = 13'h0408; burst_exp[1] = 16'h0101;
    burst[2] = 13'h0800; burst_exp[2] = 16'h0100;
    burst[3] = 13'h14F0; burst_exp[3] = 16'hF000;
    burst[4] = 13'h0401; burst_exp[4] = 16'hF002;
    burst[5] = 13'h080C; burst_exp[5] = 16'hE002;
    burst[6] = 13'h1033; burst_exp[6] = 16'hE033;
    burst[7] = 13'h040A; burst_exp[7] = 16'hE433;

    reset = 1'b0; instr_valid = 1'b0; instruction = '0; halt = 1'b0;
    #12;
    check("rst_valves", 32'(valves), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1);

    exp_prev = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].instr);
      check($sformatf("v%0d_busy_e0", i), 32'(busy), 32'h1);
      tick(1);
      check($sformatf("v%0d_valves_e1", i), 32'(valves), 32'(exp_prev));
      tick(1);
      check($sformatf("v%0d_valves_e2", i), 32'(valves), 32'(vecs[i].exp_valves));
      check($sformatf("v%0d_busy_e2", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_err", i), 32'(err), 32'h0);
      exp_prev = vecs[i].exp_valves;
    end

    push(13'h0C02);
    push(13'h0405);
    check("wait2_count_pushpop", 32'(fifo_count), 32'h1);
    tick(1);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check($sformatf("wait2_busy_%0d", k), 32'(busy), 32'h1);
      check($sformatf("wait2_hold_%0d", k), 32'(valves), 32'h0);
    end
    tick(1);
    check("wait2_valve5", 32'(valves), 32'h0020);
    check("wait2_idle", 32'(busy), 32'h0);

    push(13'h0C3F);
    tick(2);
    for (int j = 0; j < 8; j++) push(burst[j]);
    check("full_count", 32'(fifo_count), 32'h8);
    check("full_ready", 32'(instr_ready), 32'h0);
    check("full_err_before", 32'(err), 32'h0);
    push(13'h1800);
    check("ovf_count", 32'(fifo_count), 32'h8);
    check("ovf_err", 32'(err), 32'h1);
    n = 0;
    while (fifo_count != 4'd7 && n < 400) begin
      tick(1);
      n++;
    end
    check("burst_wait_end", 32'(n < 400), 32'h1);
    tick(1);
    check("burst_0", 32'(valves), 32'(burst_exp[0]));
    for (int j = 1; j < 8; j++) begin
      tick(2);
      check($sformatf("burst_%0d", j), 32'(valves), 32'(burst_exp[j]));
    end
    tick(3);
    check("burst_final", 32'(valves), 32'hE433);
    check("burst_idle", 32'(busy), 32'h0);

    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("ill_err_pre", 32'(err), 32'h0);
    push(13'h1C00);
    push(13'h10AA);
    tick(1);
    check("ill_valves", 32'(valves), 32'h0);
    check("ill_err", 32'(err), 32'h1);
    tick(2);
    check("ill_then_setlo", 32'(valves), 32'h00AA);
    check("ill_err_sticky", 32'(err), 32'h1);

    push(13'h10FF);
    tick(2);
    check("halt_pre_valves", 32'(valves), 32'h00FF);
    push(13'h0C10);
    push(13'h0401);
    push(13'h0402);
    push(13'h0403);
    check("halt_pre_count", 32'(fifo_count), 32'h3);
    check("halt_pre_busy", 32'(busy), 32'h1);
    halt = 1'b1;
    instr_valid = 1'b1;
    instruction = 13'h0404;
    tick(1);
    halt = 1'b0;
    instr_valid = 1'b0;
    check("halt_valves", 32'(valves), 32'h0);
    check("halt_count", 32'(fifo_count), 32'h0);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_err_kept", 32'(err), 32'h1);
    tick(5);
    check("halt_after_valves", 32'(valves), 32'h0);
    check("halt_after_busy", 32'(busy), 32'h0);

    push(13'h1034);
    push(13'h1412);
    push(13'h0C05);
    tick(4);
    check("rstw_valves", 32'(valves), 32'h1234);
    check("rstw_busy", 32'(busy), 32'h1);
    push(13'h1800);
    #3;
    reset = 1'b0;
    #1;
    check("rstw_async_valves", 32'(valves), 32'h0);
    check("rstw_async_err", 32'(err), 32'h0);
    check("rstw_async_busy", 32'(busy), 32'h0);
    check("rstw_async_count", 32'(fifo_count), 32'h0);
    check("rstw_async_ready", 32'(instr_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(30);
    check("rstw_idle_busy", 32'(busy), 32'h0);
    check("rstw_idle_valves", 32'(valves), 32'h0);
    check("rstw_idle_ready", 32'(instr_ready), 32'h1);
    push(13'h0401);
    tick(2);
    check("rstw_fresh_cmd", 32'(valves), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
